// File: rtl/sd_access_arbiter.sv
// Purpose: two-port round-robin arbiter sharing one SD word-access controller (port 0 boot loader, port 1 host CPU).
// Latency: grant 1 cycle after request; read ack NEXT_CYCLES+1 cycles after the controller's done rising edge.
// Backpressure: requests are level-held until ack; the losing port simply waits, there is no preemption.
// Ports: m0_*/m1_* requester side (req/we/addr/wdata in, gnt/ack/err/rdata out),
//        sd_* controller side (addr/we/re/dataw/nextoper out, done/rdata in), control_clk_i, control_rst_i (sync, active-low).
module sd_access_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int NEXT_CYCLES    = 2
) (
    input  logic              control_clk_i,
    input  logic              control_rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] sd_addr_o,
    output logic              sd_we_o,
    output logic              sd_re_o,
    output logic [DATA_W-1:0] sd_dataw_o,
    output logic              sd_nextoper_o,
    input  logic              sd_done_i,
    input  logic [DATA_W-1:0] sd_rdata_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam int TO_CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_CLOG > 16) ? TO_CLOG : 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int NX_W    = (NEXT_CYCLES > 1) ? $clog2(NEXT_CYCLES) : 1;
    localparam logic [NX_W-1:0] NX_LAST = NX_W'(NEXT_CYCLES - 1);

    logic [2:0]        state_q;
    logic              owner_q;     // 0 = port 0, 1 = port 1
    logic              last_q;      // port granted most recently
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [NX_W-1:0]   nx_cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              pick1;
    logic              busy;
    logic              drive;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign pick1 = m1_req_i & (~m0_req_i | ~last_q);

    always_ff @(posedge control_clk_i) begin
        if (!control_rst_i) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;   // makes port 0 win the first tie
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            to_cnt_q <= '0;
            nx_cnt_q <= '0;
            err_q    <= 1'b0;
            res_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        owner_q <= pick1;
                        we_q    <= pick1 ? m1_we_i    : m0_we_i;
                        addr_q  <= pick1 ? m1_addr_i  : m0_addr_i;
                        wdata_q <= pick1 ? m1_wdata_i : m0_wdata_i;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Seed the edge detector so a done left high by the previous op is not taken as completion.
                    done_q   <= sd_done_i;
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    done_q <= sd_done_i;
                    if (!done_q && sd_done_i) begin
                        res_q    <= sd_rdata_i;
                        err_q    <= 1'b0;
                        nx_cnt_q <= '0;
                        state_q  <= S_NEXT;
                    end else if (to_cnt_q == TO_LAST) begin
                        res_q    <= '0;
                        err_q    <= 1'b1;
                        nx_cnt_q <= '0;
                        state_q  <= S_NEXT;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_NEXT: begin
                    if (nx_cnt_q == NX_LAST) begin
                        // Result lands in the owner's rdata register so it is valid alongside ack.
                        // Successful writes keep the previous read value; a timeout reports zero.
                        if (!we_q || err_q) begin
                            if (owner_q) rdata1_q <= res_q;
                            else         rdata0_q <= res_q;
                        end
                        state_q <= S_RESP;
                    end else begin
                        nx_cnt_q <= nx_cnt_q + NX_W'(1);
                    end
                end
                S_RESP: begin
                    last_q   <= owner_q;
                    to_cnt_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign drive = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);

    assign m0_gnt_o = busy & ~owner_q;
    assign m1_gnt_o = busy &  owner_q;
    assign m0_ack_o = (state_q == S_RESP) & ~owner_q;
    assign m1_ack_o = (state_q == S_RESP) &  owner_q;
    assign m0_err_o = m0_ack_o & err_q;
    assign m1_err_o = m1_ack_o & err_q;
    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;

    assign sd_addr_o     = addr_q;
    assign sd_dataw_o    = wdata_q;
    assign sd_we_o       = drive &  we_q;
    assign sd_re_o       = drive & ~we_q;
    assign sd_nextoper_o = (state_q == S_NEXT);

endmodule

// File: tb/tb_sd_access_arbiter.sv
module tb_sd_access_arbiter;

    localparam int TO = 100;
    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata, sd_addr, sd_dataw;
    logic        sd_we, sd_re, sd_next;
    logic        sd_done = 0;
    logic [31:0] sd_rdata = 0;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_exp, mon_act;
    logic [31:0] exp_rd0 = 0, exp_rd1 = 0;
    int          vectors = 0;
    int          miscompares = 0;

    sd_access_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .NEXT_CYCLES(NC)
    ) dut (
        .control_clk_i(clk), .control_rst_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .sd_addr_o(sd_addr), .sd_we_o(sd_we), .sd_re_o(sd_re), .sd_dataw_o(sd_dataw),
        .sd_nextoper_o(sd_next), .sd_done_i(sd_done), .sd_rdata_i(sd_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every ack pops the oldest expectation; exclusivity checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ((m0_gnt && m1_gnt) || (sd_we && sd_re)) begin
                miscompares++;
                $display("FAIL exclusive: gnt=%b%b we/re=%b%b, required at most one of each", m1_gnt, m0_gnt, sd_we, sd_re);
            end
            if (m0_ack || m1_ack) begin
                vectors++;
                if (sb.size() == 0 || (m0_ack && m1_ack)) begin
                    miscompares++;
                    $display("FAIL ack_unexpected: m0_ack=%b m1_ack=%b, required no ack", m0_ack, m1_ack);
                end else begin
                    mon_exp = sb.pop_front();
                    mon_act.port  = m1_ack;
                    mon_act.err   = m1_ack ? m1_err : m0_err;
                    mon_act.rdata = m1_ack ? m1_rdata : m0_rdata;
                    if (mon_act !== mon_exp) begin
                        miscompares++;
                        $display("FAIL ack_result: port/err/rdata=%0d/%0d/%h, required %0d/%0d/%h",
                                 mon_act.port, mon_act.err, mon_act.rdata, mon_exp.port, mon_exp.err, mon_exp.rdata);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 0; m0_req = 0; m1_req = 0; sd_done = 0;
        repeat (2) tick();
        rst_n = 1;
        exp_rd0 = 0; exp_rd1 = 0;
    endtask

    task automatic wait_issue(output bit seen);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (sd_we || sd_re) seen = 1;
        end
    endtask

    // Counts negedges without ack (lat) and nextoper-high cycles until the given port acks.
    task automatic run_to_ack(input bit port, input int max, output int lat, output int nxt, output bit seen);
        lat = 0; nxt = 0; seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (sd_next) nxt++;
            if (port ? m1_ack : m0_ack) seen = 1;
            else lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, sd_we, sd_re, sd_next} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: %b, required 000000000",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, sd_we, sd_re, sd_next});
        end
        vectors++;
        if ({sd_addr, sd_dataw, m0_rdata, m1_rdata} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h dataw=%h rd0=%h rd1=%h, required all 0", sd_addr, sd_dataw, m0_rdata, m1_rdata);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_single_read();
        bit seen; int lat, nxt;
        m0_we = 0; m0_addr = 32'hFAFAFAFA; m0_req = 1;
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h12345678});
        exp_rd0 = 32'h12345678;
        wait_issue(seen);
        vectors++;
        if (!(seen && sd_re === 1'b1 && sd_we === 1'b0 && m0_gnt === 1'b1 && m1_gnt === 1'b0)) begin
            miscompares++;
            $display("FAIL read_issue: seen=%b re=%b we=%b gnt=%b%b, required 1 1 0 01", seen, sd_re, sd_we, m1_gnt, m0_gnt);
        end
        tick();
        m0_addr = 32'h0;   // must be ignored, address was latched at grant
        repeat (39) tick();
        vectors++;
        if (sd_addr !== 32'hFAFAFAFA) begin
            miscompares++;
            $display("FAIL read_addr: %h, required fafafafa", sd_addr);
        end
        sd_rdata = 32'h12345678; sd_done = 1;
        run_to_ack(1'b0, 20, lat, nxt, seen);
        vectors++;
        if (!seen || lat != NC + 1 || nxt != NC) begin
            miscompares++;
            $display("FAIL read_timing: seen=%b lat=%0d next=%0d, required 1 %0d %0d", seen, lat, nxt, NC + 1, NC);
        end
        tick();
        m0_req = 0; sd_done = 0; sd_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (m0_ack !== 1'b0 || m0_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL read_hold: ack=%b rdata=%h, required 0 12345678", m0_ack, m0_rdata);
        end
    endtask

    task automatic test_single_write();
        bit seen; int lat, nxt;
        m1_we = 1; m1_addr = 32'h123; m1_wdata = 32'hEDEDEDE1; m1_req = 1;
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: exp_rd1});
        wait_issue(seen);
        vectors++;
        if (!(seen && sd_we === 1'b1 && sd_re === 1'b0 && sd_dataw === 32'hEDEDEDE1 && m1_gnt === 1'b1 && m0_gnt === 1'b0)) begin
            miscompares++;
            $display("FAIL write_issue: seen=%b we=%b re=%b dataw=%h gnt=%b%b, required 1 1 0 ededede1 10",
                     seen, sd_we, sd_re, sd_dataw, m1_gnt, m0_gnt);
        end
        repeat (5) tick();
        sd_rdata = 32'hDEADBEEF; sd_done = 1;
        run_to_ack(1'b1, 20, lat, nxt, seen);
        vectors++;
        if (!seen || nxt != NC) begin
            miscompares++;
            $display("FAIL write_timing: seen=%b next=%0d, required 1 %0d", seen, nxt, NC);
        end
        tick();
        m1_req = 0; sd_done = 0;
        @(negedge clk);
        vectors++;
        if (m1_rdata !== exp_rd1) begin
            miscompares++;
            $display("FAIL write_rdata: %h, required %h", m1_rdata, exp_rd1);
        end
    endtask

    task automatic test_stale_done();
        bit seen, early; int lat, nxt;
        sd_done = 1; sd_rdata = 32'hBAD0BAD0;
        m0_we = 0; m0_addr = 32'h55; m0_req = 1;
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hCAFEF00D});
        exp_rd0 = 32'hCAFEF00D;
        wait_issue(seen);
        repeat (3) tick();
        sd_done = 0;
        early = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sd_next || m0_ack) early = 1;
        end
        tick();
        sd_done = 1; sd_rdata = 32'hCAFEF00D;
        run_to_ack(1'b0, 20, lat, nxt, seen);
        vectors++;
        if (early || !seen || lat != NC + 1) begin
            miscompares++;
            $display("FAIL stale_done: early=%b seen=%b lat=%0d, required 0 1 %0d", early, seen, lat, NC + 1);
        end
        tick();
        m0_req = 0; sd_done = 0;
    endtask

    task automatic test_timeout();
        bit seen; int lat, nxt;
        sd_done = 0;
        m1_we = 0; m1_addr = 32'h77; m1_req = 1;
        sb.push_back('{port: 1'b1, err: 1'b1, rdata: 32'h0});
        exp_rd1 = 32'h0;
        wait_issue(seen);
        run_to_ack(1'b1, 300, lat, nxt, seen);
        vectors++;
        if (!seen || lat != TO + NC || nxt != NC) begin
            miscompares++;
            $display("FAIL timeout: seen=%b lat=%0d next=%0d, required 1 %0d %0d", seen, lat, nxt, TO + NC, NC);
        end
        tick();
        m1_req = 0;
    endtask

    task automatic test_contention();
        bit seen; int lat, nxt;
        logic p;
        reset_dut();
        m0_we = 0; m0_addr = 32'h10; m1_we = 0; m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{port: i[0], err: 1'b0, rdata: 32'hA0000000 + 32'(i)});
        end
        exp_rd0 = 32'hA0000002; exp_rd1 = 32'hA0000003;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            p = i[0];
            wait_issue(seen);
            vectors++;
            if (!seen || {m1_gnt, m0_gnt} !== (p ? 2'b10 : 2'b01) || sd_addr !== (p ? 32'h20 : 32'h10)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: seen=%b gnt=%b%b addr=%h, required port %0d", i, seen, m1_gnt, m0_gnt, sd_addr, p);
            end
            repeat (3) tick();
            sd_done = 1; sd_rdata = 32'hA0000000 + 32'(i);
            run_to_ack(p, 20, lat, nxt, seen);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL rr_ack%0d: no ack on port %0d, required ack", i, p);
            end
            tick();
            sd_done = 0;
            if (i == 2) m0_req = 0;
            if (i == 3) m1_req = 0;
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen; int lat, nxt;
        m0_we = 0; m0_addr = 32'h99; m0_req = 1;
        wait_issue(seen);
        repeat (5) tick();
        rst_n = 0; m0_req = 0;
        tick();
        rst_n = 1;
        exp_rd0 = 0; exp_rd1 = 0;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, sd_we, sd_re, sd_next} !== 7'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset: ctrl=%b rd0=%h rd1=%h, required all 0",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, sd_we, sd_re, sd_next}, m0_rdata, m1_rdata);
        end
        m1_we = 0; m1_addr = 32'h44; m1_req = 1;
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0BADF00D});
        exp_rd1 = 32'h0BADF00D;
        wait_issue(seen);
        vectors++;
        if (!seen || m1_gnt !== 1'b1 || sd_addr !== 32'h44) begin
            miscompares++;
            $display("FAIL post_reset_issue: seen=%b gnt1=%b addr=%h, required 1 1 00000044", seen, m1_gnt, sd_addr);
        end
        repeat (4) tick();
        sd_done = 1; sd_rdata = 32'h0BADF00D;
        run_to_ack(1'b1, 20, lat, nxt, seen);
        vectors++;
        if (!seen || lat != NC + 1) begin
            miscompares++;
            $display("FAIL post_reset_ack: seen=%b lat=%0d, required 1 %0d", seen, lat, NC + 1);
        end
        tick();
        m1_req = 0; sd_done = 0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_stale_done();
        test_timeout();
        test_contention();
        test_reset_mid_wait();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected acks outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
